// File: rtl/integer_sequential_divider.sv
// Restoring sequential divider, one quotient bit per enabled clock.
// INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN selects two's-complement operands.
module integer_sequential_divider #(
    parameter int N_WIDTH = 24,
    parameter int D_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               start,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_zero
);

    localparam int CW = $clog2(N_WIDTH);

`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX, FINISH} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
`endif

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [N_WIDTH-1:0] dreg, dreg_n;
    logic [D_WIDTH-1:0] dsor, dsor_n;
    logic [D_WIDTH-1:0] prem, prem_n;
    logic               dz, dz_n;
    logic               busy_n, done_n, div_zero_n;
    logic [N_WIDTH-1:0] quotient_n;
    logic [D_WIDTH-1:0] remainder_n;

    logic [D_WIDTH:0]   minuend;
    logic [D_WIDTH-1:0] diff, prem_step;
    logic               no_borrow;
    logic [N_WIDTH-1:0] dreg_step, dvd_load;
    logic [D_WIDTH-1:0] dsr_load;

`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
    logic neg_q, neg_q_n, neg_r, neg_r_n;

    // Raw dividend is kept on divide-by-zero so the remainder passes it through.
    assign dvd_load = (divisor == '0 || !dividend[N_WIDTH-1]) ? dividend : -dividend;
    assign dsr_load = divisor[D_WIDTH-1] ? -divisor : divisor;
`else
    assign dvd_load = dividend;
    assign dsr_load = divisor;
`endif

    // The partial remainder is always below the divisor, so D bits hold it.
    assign minuend   = {prem, dreg[N_WIDTH-1]};
    assign no_borrow = minuend >= {1'b0, dsor};
    assign diff      = minuend[D_WIDTH-1:0] - dsor;
    assign prem_step = no_borrow ? diff : minuend[D_WIDTH-1:0];
    assign dreg_step = {dreg[N_WIDTH-2:0], no_borrow};

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dreg_n      = dreg;
        dsor_n      = dsor;
        prem_n      = prem;
        dz_n        = dz;
        busy_n      = busy;
        done_n      = 1'b0;
        quotient_n  = quotient;
        remainder_n = remainder;
        div_zero_n  = div_zero;
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
        neg_q_n     = neg_q;
        neg_r_n     = neg_r;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    dreg_n  = dvd_load;
                    dsor_n  = dsr_load;
                    prem_n  = '0;
                    cnt_n   = CW'(N_WIDTH - 1);
                    busy_n  = 1'b1;
                    dz_n    = (divisor == '0);
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
                    neg_q_n = dividend[N_WIDTH-1] ^ divisor[D_WIDTH-1];
                    neg_r_n = dividend[N_WIDTH-1];
`endif
                    state_n = (divisor == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                prem_n = prem_step;
                dreg_n = dreg_step;
                cnt_n  = cnt - CW'(1);
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
                if (cnt == '0) state_n = FIX;
`else
                // Last bit is resolved while registering in FINISH.
                if (cnt == CW'(1)) state_n = FINISH;
`endif
            end
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
            FIX: begin
                quotient_n  = neg_q ? -dreg : dreg;
                remainder_n = neg_r ? -prem : prem;
                div_zero_n  = 1'b0;
                done_n      = 1'b1;
                busy_n      = 1'b0;
                state_n     = IDLE;
            end
`endif
            FINISH: begin
                quotient_n  = '1;
                remainder_n = dreg[D_WIDTH-1:0];
`ifndef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
                if (!dz) begin
                    quotient_n  = dreg_step;
                    remainder_n = prem_step;
                end
`endif
                div_zero_n  = dz;
                done_n      = 1'b1;
                busy_n      = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dreg      <= '0;
            dsor      <= '0;
            prem      <= '0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else if (ena) begin
            state     <= state_n;
            cnt       <= cnt_n;
            dreg      <= dreg_n;
            dsor      <= dsor_n;
            prem      <= prem_n;
            dz        <= dz_n;
            busy      <= busy_n;
            done      <= done_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
            div_zero  <= div_zero_n;
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
            neg_q     <= neg_q_n;
            neg_r     <= neg_r_n;
`endif
        end
    end

endmodule

// File: tb/tb_integer_sequential_divider.sv
// Scoreboard bench for integer_sequential_divider (N_WIDTH=24, D_WIDTH=16).
// Follows INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN when defined for the build.
module tb_integer_sequential_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic [23:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_zero;
    logic [23:0] quotient;
    logic [15:0] remainder;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    integer_sequential_divider #(.N_WIDTH(24), .D_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(logic [23:0] a, logic [15:0] b);
        exp_t e;
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
        longint sa, sb;
`endif
        e.dz = (b == 16'd0);
        if (e.dz) begin
            e.q = 24'hFFFFFF;
            e.r = a[15:0];
            e.lat = 1;
        end else begin
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            e.q = 24'(sa / sb);
            e.r = 16'(sa % sb);
            e.lat = 25;
`else
            e.q = a / {8'd0, b};
            e.r = 16'(a % {8'd0, b});
            e.lat = 24;
`endif
        end
        return e;
    endfunction

    // Starts one op, scrambles operands afterwards, waits for done.
    task automatic do_op(input logic [23:0] a, input logic [15:0] b,
                         input bit tog, output int lat);
        int n;
        logic en;
        exp_q.push_back(model(a, b));
        ena = 1'b1;
        dividend = a;
        divisor = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        dividend = 24'($urandom);
        divisor = 16'($urandom);
        n = 0;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            if (tog) ena = k[0];
            en = ena;
            tick();
            if (en) n++;
            if (done) begin
                lat = n;
                break;
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b dz=%b want 0 0 0", busy, done, div_zero);
        end
        checks++;
        if (quotient !== 24'd0 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL reset_data q=%h r=%h want 0 0", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int lat;
        do_op(24'd100, 16'd7, 1'b0, lat);
        e = exp_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
            errors++;
            $display("FAIL basic q=%h r=%h dz=%b want %h %h %b",
                     quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done got %b want 0", busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || quotient !== e.q) begin
            errors++;
            $display("FAIL done_pulse done=%b q=%h want 0 %h", done, quotient, e.q);
        end
    endtask

    task automatic test_boundary();
        logic [23:0] ta[$];
        logic [15:0] tb[$];
        exp_t e;
        int lat;
        ta = '{24'hFFFFFF, 24'd5, 24'h123456, 24'd100, 24'd0, 24'h7FFFFF};
        tb = '{16'hFFFF, 16'd9, 16'd0, 16'd7, 16'd3, 16'h0001};
`ifdef INTEGER_SEQUENTIAL_DIVIDER_SIGNED_EN
        ta.push_back(24'hFFFF9C); tb.push_back(16'd7);
        ta.push_back(24'd100);    tb.push_back(16'hFFF9);
        ta.push_back(24'h800000); tb.push_back(16'hFFFF);
        ta.push_back(24'h800000); tb.push_back(16'h8000);
`endif
        foreach (ta[i]) begin
            do_op(ta[i], tb[i], 1'b0, lat);
            e = exp_q.pop_front();
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
                errors++;
                $display("FAIL boundary_%0d q=%h r=%h dz=%b want %h %h %b",
                         i, quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL boundary_lat_%0d got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        int n;
        int lat;
        exp_q.push_back(model(24'h0ABCDE, 16'd321));
        dividend = 24'h0ABCDE;
        divisor = 16'd321;
        start = 1'b1;
        tick();
        n = 0;
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            start = (n == 2 || n == 9);
            dividend = 24'($urandom);
            divisor = 16'($urandom_range(0, 5));
            tick();
            n++;
            if (n == 5) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid_run got %b want 1", busy);
                end
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || lat !== e.lat) begin
            errors++;
            $display("FAIL start_busy q=%h r=%h lat=%0d want %h %h %0d",
                     quotient, remainder, lat, e.q, e.r, e.lat);
        end
        n = 0;
        repeat (5) begin
            tick();
            if (busy || done) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL no_queue active_cycles=%0d want 0", n);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        int lat;
        exp_q.push_back(model(24'd1000, 16'd33));
        dividend = 24'd1000;
        divisor = 16'd33;
        start = 1'b1;
        tick();
        dividend = 24'd200;
        divisor = 16'd3;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done) break;
        end
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || quotient !== e.q || remainder !== e.r) begin
            errors++;
            $display("FAIL b2b_first done=%b q=%h r=%h want 1 %h %h",
                     done, quotient, remainder, e.q, e.r);
        end
        exp_q.push_back(model(24'd200, 16'd3));
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy, done);
        end
        n = 1;
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = n;
                break;
            end
            tick();
            n++;
        end
        lat = lat - 1;
        e = exp_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || lat !== e.lat) begin
            errors++;
            $display("FAIL b2b_second q=%h r=%h lat=%0d want %h %h %0d",
                     quotient, remainder, lat, e.q, e.r, e.lat);
        end
    endtask

    task automatic test_ena();
        exp_t e;
        int lat;
        do_op(24'h00F00D, 16'd77, 1'b1, lat);
        e = exp_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || lat !== e.lat) begin
            errors++;
            $display("FAIL ena_toggle q=%h r=%h lat=%0d want %h %h %0d",
                     quotient, remainder, lat, e.q, e.r, e.lat);
        end
        ena = 1'b0;
        repeat (3) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ena_hold_done got %b want 1", done);
        end
        ena = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ena_release_done got %b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        dividend = 24'h654321;
        divisor = 16'd19;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 24'd0 ||
            remainder !== 16'd0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        tick();
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            tick();
            if (done || busy) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done active_cycles=%0d want 0", n);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int lat;
        logic [23:0] a;
        logic [15:0] b;
        for (int k = 0; k < 1200; k++) begin
            a = 24'($urandom);
            b = 16'($urandom);
            if (k % 8 == 0) b = 16'd0;
            if (k % 8 == 1) b = 16'($urandom_range(1, 15));
            if (k % 8 == 2) a = 24'($urandom_range(0, 4000));
            if (k % 50 == 3) begin
                a = 24'h800000;
                b = 16'hFFFF;
            end
            do_op(a, b, k % 16 == 5, lat);
            e = exp_q.pop_front();
            checks++;
            if (quotient !== e.q || remainder !== e.r ||
                div_zero !== e.dz || lat !== e.lat) begin
                errors++;
                $display("FAIL random a=%h b=%h q=%h r=%h dz=%b lat=%0d want %h %h %b %0d",
                         a, b, quotient, remainder, div_zero, lat,
                         e.q, e.r, e.dz, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_start_while_busy();
        test_back_to_back();
        test_ena();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
